// File: rtl/tuser_merge_fifo.sv
// Merges per-packet metadata tuples onto an AXIS packet stream as tuser.
// Tuples queue in a small FIFO so they may arrive before their packets.
module tuser_merge_fifo #(
  parameter int DATA_WIDTH       = 256,
  parameter int TUPLE_WIDTH      = 128,
  parameter int TUPLE_DEPTH      = 4,
  parameter int TUSER_FIRST_ONLY = 0
) (
  input  logic                      tout_aclk,
  input  logic                      tout_arst_n,
  input  logic                      tout_avalid,
  output logic                      tout_aready,
  input  logic [DATA_WIDTH-1:0]     tout_adata,
  input  logic [DATA_WIDTH/8-1:0]   tout_akeep,
  input  logic                      tout_atlast,
  input  logic                      tout_valid,
  output logic                      tout_tready,
  input  logic [TUPLE_WIDTH-1:0]    tout_data,
  output logic                      tout_bvalid,
  input  logic                      tout_bready,
  output logic [DATA_WIDTH-1:0]     tout_bdata,
  output logic [DATA_WIDTH/8-1:0]   tout_bkeep,
  output logic                      tout_btlast,
  output logic [TUPLE_WIDTH-1:0]    tout_btuser,
  output logic [1:0]                dbg_state,
  output logic [31:0]               dbg_pkt_cnt,
  output logic [15:0]               dbg_drop_cnt,
  output logic                      dbg_ovf
);

  localparam int AW = $clog2(TUPLE_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TUPLE_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'b00, PKT = 2'b01} state_e;

  state_e                     state_q;
  logic [TUPLE_WIDTH-1:0]     fifo_q [TUPLE_DEPTH];
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [AW:0]                cnt_q, cnt_d;
  logic [TUPLE_WIDTH-1:0]     cur_tuple_q, head_tuple, tuser_d;

  logic                       bvalid_q, btlast_q;
  logic [DATA_WIDTH-1:0]      bdata_q;
  logic [DATA_WIDTH/8-1:0]    bkeep_q;
  logic [TUPLE_WIDTH-1:0]     btuser_q;

  logic [31:0]                pkt_cnt_q;
  logic [15:0]                drop_cnt_q;
  logic                       ovf_q;

  logic empty, full, push, pop, drop, slot_free, accept;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign push       = tout_valid & ~full;
  assign drop       = tout_valid & full;
  assign slot_free  = ~bvalid_q | tout_bready;
  assign tout_aready = slot_free & ((state_q == PKT) | ~empty);
  assign accept     = tout_avalid & tout_aready;
  // The head tuple is consumed by the first beat of each packet.
  assign pop        = accept & (state_q == IDLE);
  assign head_tuple = fifo_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    tuser_d = cur_tuple_q;
    if (state_q == IDLE)            tuser_d = head_tuple;
    else if (TUSER_FIRST_ONLY != 0) tuser_d = '0;
  end

  // Tuple storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge tout_aclk) begin
    if (push) fifo_q[wr_ptr_q] <= tout_data;
  end

  always_ff @(posedge tout_aclk or negedge tout_arst_n) begin
    if (!tout_arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge tout_aclk or negedge tout_arst_n) begin
    if (!tout_arst_n) begin
      state_q     <= IDLE;
      cur_tuple_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          cur_tuple_q <= head_tuple;
          if (!tout_atlast) state_q <= PKT;
        end
        PKT:  if (accept && tout_atlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output slice: load on accept, otherwise retire the beat once taken.
  always_ff @(posedge tout_aclk or negedge tout_arst_n) begin
    if (!tout_arst_n) begin
      bvalid_q <= 1'b0;
      bdata_q  <= '0;
      bkeep_q  <= '0;
      btlast_q <= 1'b0;
      btuser_q <= '0;
    end else if (accept) begin
      bvalid_q <= 1'b1;
      bdata_q  <= tout_adata;
      bkeep_q  <= tout_akeep;
      btlast_q <= tout_atlast;
      btuser_q <= tuser_d;
    end else if (tout_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge tout_aclk or negedge tout_arst_n) begin
    if (!tout_arst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (bvalid_q && tout_bready && btlast_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign tout_tready  = ~full;
  assign tout_bvalid  = bvalid_q;
  assign tout_bdata   = bdata_q;
  assign tout_bkeep   = bkeep_q;
  assign tout_btlast  = btlast_q;
  assign tout_btuser  = btuser_q;
  assign dbg_state    = state_q;
  assign dbg_pkt_cnt  = pkt_cnt_q;
  assign dbg_drop_cnt = drop_cnt_q;
  assign dbg_ovf      = ovf_q;

endmodule

// File: tb/tb_tuser_merge_fifo.sv
// Bench for tuser_merge_fifo: directed and randomized packets checked against
// a queue-based model of tuple ordering plus an output-stream scoreboard.
module tb_tuser_merge_fifo;
  localparam int DW = 256, TW = 128, KW = DW/8, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, avalid, aready, atlast, tvalid, tready, bvalid, bready, btlast, ovf;
  logic [DW-1:0] adata, bdata;
  logic [KW-1:0] akeep, bkeep;
  logic [TW-1:0] tdata, btuser;
  logic [1:0]    dstate;
  logic [31:0]   pkt;
  logic [15:0]   drop;

  logic f_rst_n, f_avalid, f_aready, f_atlast, f_tvalid, f_tready, f_bvalid, f_bready, f_btlast, f_ovf;
  logic [DW-1:0] f_adata, f_bdata;
  logic [KW-1:0] f_akeep, f_bkeep;
  logic [TW-1:0] f_tdata, f_btuser;
  logic [1:0]    f_dstate;
  logic [31:0]   f_pkt;
  logic [15:0]   f_drop;

  tuser_merge_fifo #(.DATA_WIDTH(DW), .TUPLE_WIDTH(TW), .TUPLE_DEPTH(DEPTH), .TUSER_FIRST_ONLY(0)) dut (
    .tout_aclk(clk), .tout_arst_n(rst_n), .tout_avalid(avalid), .tout_aready(aready),
    .tout_adata(adata), .tout_akeep(akeep), .tout_atlast(atlast), .tout_valid(tvalid),
    .tout_tready(tready), .tout_data(tdata), .tout_bvalid(bvalid), .tout_bready(bready),
    .tout_bdata(bdata), .tout_bkeep(bkeep), .tout_btlast(btlast), .tout_btuser(btuser),
    .dbg_state(dstate), .dbg_pkt_cnt(pkt), .dbg_drop_cnt(drop), .dbg_ovf(ovf));

  tuser_merge_fifo #(.DATA_WIDTH(DW), .TUPLE_WIDTH(TW), .TUPLE_DEPTH(DEPTH), .TUSER_FIRST_ONLY(1)) dut_f (
    .tout_aclk(clk), .tout_arst_n(f_rst_n), .tout_avalid(f_avalid), .tout_aready(f_aready),
    .tout_adata(f_adata), .tout_akeep(f_akeep), .tout_atlast(f_atlast), .tout_valid(f_tvalid),
    .tout_tready(f_tready), .tout_data(f_tdata), .tout_bvalid(f_bvalid), .tout_bready(f_bready),
    .tout_bdata(f_bdata), .tout_bkeep(f_bkeep), .tout_btlast(f_btlast), .tout_btuser(f_btuser),
    .dbg_state(f_dstate), .dbg_pkt_cnt(f_pkt), .dbg_drop_cnt(f_drop), .dbg_ovf(f_ovf));

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [TW-1:0] u;
  } beat_t;

  beat_t         exp_q[$];
  logic [TW-1:0] mq[$];
  int total = 0, bad = 0, model_pkts = 0, model_drops = 0;

  bit   rand_ready = 1'b0, rnd_ready = 1'b1;
  logic bready_dir = 1'b1;
  assign bready = rand_ready ? rnd_ready : bready_dir;
  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output scoreboard: every completed handshake must match the next expected
  // beat, and a stalled beat must not change.
  bit    mon_stall = 1'b0;
  beat_t mon_prev, mon_e;
  always @(negedge clk) begin
    if (!rst_n) mon_stall = 1'b0;
    else begin
      if (mon_stall) begin
        chk("hold_valid", bvalid, 1'b1);
        chk("hold_data", bdata, mon_prev.d);
        chk("hold_keep", bkeep, mon_prev.k);
        chk("hold_last", btlast, mon_prev.l);
        chk("hold_user", btuser, mon_prev.u);
      end
      if (bvalid && bready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_data", bdata, mon_e.d);
          chk("sb_keep", bkeep, mon_e.k);
          chk("sb_last", btlast, mon_e.l);
          chk("sb_user", btuser, mon_e.u);
        end
      end
      mon_stall = bvalid && !bready;
      mon_prev  = '{bdata, bkeep, btlast, btuser};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tuple(input logic [TW-1:0] t);
    chk("tready_before_push", tready, mq.size() < DEPTH);
    tvalid = 1'b1;
    tdata  = t;
    tick();
    tvalid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(t);
    else model_drops++;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [TW-1:0] u, output bit ok, output int waited);
    avalid = 1'b1; adata = d; akeep = k; atlast = l;
    ok = 1'b0; waited = 0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (aready) begin
        ok = 1'b1;
        exp_q.push_back('{d, k, l, u});
      end else waited++;
      tick();
    end
    avalid = 1'b0;
    chk("accept_in_time", ok, 1'b1);
  endtask

  task automatic rand_data(output logic [DW-1:0] d);
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
  endtask

  // A packet's tuser is the oldest buffered tuple, repeated on every beat.
  task automatic send_pkt(input int len, input bit fixed, input logic [DW-1:0] d0,
                          input logic [KW-1:0] k0, input int gap_max, output int first_wait);
    logic [TW-1:0] u;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    bit ok;
    int w;
    u = '0;
    first_wait = -1;
    if (mq.size() != 0) u = mq.pop_front();
    for (int i = 0; i < len; i++) begin
      if (fixed) begin d = d0; k = k0; end
      else begin rand_data(d); k = KW'($urandom); end
      if (i > 0) repeat ($urandom_range(0, gap_max)) tick();
      send_beat(d, k, i == len-1, u, ok, w);
      if (i == 0) first_wait = w;
      if (ok) begin
        chk("out_valid", bvalid, 1'b1);
        chk("out_data", bdata, d);
        chk("out_keep", bkeep, k);
        chk("out_user", btuser, u);
        chk("out_last", btlast, i == len-1);
        chk("state_after_beat", dstate, (i == len-1) ? 2'b00 : 2'b01);
        chk("tready_after_beat", tready, mq.size() < DEPTH);
      end
    end
    model_pkts++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    tick();
    chk("idle_valid", bvalid, 1'b0);
    chk("pkt_cnt", pkt, model_pkts);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k;
    bit ok;
    logic [TW-1:0] t, u;
    logic [DW-1:0] d;

    rst_n = 1'b0; avalid = 1'b0; adata = '0; akeep = '0; atlast = 1'b0; tvalid = 1'b0; tdata = '0;
    f_rst_n = 1'b0; f_avalid = 1'b0; f_adata = '0; f_akeep = '0; f_atlast = 1'b0;
    f_tvalid = 1'b0; f_tdata = '0; f_bready = 1'b1;
    repeat (3) tick();
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bdata", bdata, '0);
    chk("rst_btuser", btuser, '0);
    chk("rst_btlast", btlast, 1'b0);
    chk("rst_tready", tready, 1'b1);
    chk("rst_aready", aready, 1'b0);
    chk("rst_state", dstate, 2'b00);
    chk("rst_pkt", pkt, 0);
    chk("rst_drop", drop, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_f_tready", f_tready, 1'b1);
    rst_n = 1'b1; f_rst_n = 1'b1;
    tick();

    // Single tuple, 3-beat packet with fixed payload.
    push_tuple(TW'('h44444));
    send_pkt(3, 1'b1, DW'('h22222), KW'('h33333), 0, w);
    drain();
    chk("t1_aready_empty", aready, 1'b0);
    chk("t1_tready", tready, 1'b1);

    // Fill the FIFO, then four 2-beat packets consume tuples in order.
    for (int i = 1; i <= 4; i++) push_tuple(TW'(i));
    chk("t2_full_tready", tready, 1'b0);
    repeat (4) send_pkt(2, 1'b0, '0, '0, 0, w);
    drain();

    // Overflow: tuples five and six are dropped.
    for (int i = 'h11; i <= 'h16; i++) push_tuple(TW'(i));
    chk("t3_drop", drop, model_drops);
    chk("t3_drop_two", model_drops, 2);
    chk("t3_ovf", ovf, 1'b1);
    repeat (4) send_pkt($urandom_range(1, 3), 1'b0, '0, '0, 1, w);
    drain();
    chk("t3_aready_empty", aready, 1'b0);

    // Packet waits for its tuple.
    avalid = 1'b1; adata = DW'('hBEEF); akeep = '1; atlast = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_aready_wait", aready, 1'b0);
      chk("t4_no_output", bvalid, 1'b0);
      tick();
    end
    tvalid = 1'b1; tdata = TW'(7);
    @(negedge clk);
    chk("t4_aready_same_cycle", aready, 1'b0);
    tick();
    tvalid = 1'b0;
    mq.push_back(TW'(7));
    send_pkt(2, 1'b1, DW'('hBEEF), '1, 0, w);
    chk("t4_first_wait", w, 0);
    drain();

    // Backpressure pattern during a 4-beat packet.
    push_tuple(TW'('h55));
    fork
      send_pkt(4, 1'b0, '0, '0, 0, w);
      begin
        bready_dir = 1'b1; tick();
        bready_dir = 1'b0; tick();
        bready_dir = 1'b0; tick();
        bready_dir = 1'b1;
      end
    join
    drain();

    // Randomized bursts with random backpressure and occasional overflow.
    rand_ready = 1'b1;
    repeat (20) begin
      k = $urandom_range(1, 6);
      repeat (k) begin
        t = {$urandom, $urandom, $urandom, $urandom};
        push_tuple(t);
      end
      chk("rnd_drop", drop, model_drops);
      k = mq.size();
      repeat (k) send_pkt($urandom_range(1, 5), 1'b0, '0, '0, 2, w);
      drain();
    end
    chk("rnd_ovf", ovf, model_drops != 0);
    rand_ready = 1'b0;
    bready_dir = 1'b1;

    // Reset in the middle of a stalled packet with tuples still buffered.
    for (int i = 0; i < 3; i++) push_tuple(TW'('h90 + i));
    u = mq.pop_front();
    rand_data(d);
    send_beat(d, '1, 1'b0, u, ok, w);
    rand_data(d);
    send_beat(d, '1, 1'b0, u, ok, w);
    bready_dir = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_bvalid", bvalid, 1'b0);
    chk("mr_bdata", bdata, '0);
    chk("mr_bkeep", bkeep, '0);
    chk("mr_btuser", btuser, '0);
    chk("mr_state", dstate, 2'b00);
    chk("mr_pkt", pkt, 0);
    chk("mr_ovf", ovf, 1'b0);
    chk("mr_tready", tready, 1'b1);
    exp_q.delete(); mq.delete(); model_pkts = 0; model_drops = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; bready_dir = 1'b1;
    tick();
    avalid = 1'b1;
    #1;
    chk("mr_fifo_empty", aready, 1'b0);
    avalid = 1'b0;
    push_tuple(TW'(9));
    send_pkt(2, 1'b0, '0, '0, 0, w);
    drain();

    // First-beat-only tuser instance.
    f_tvalid = 1'b1; f_tdata = TW'('hABCD);
    tick();
    f_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_avalid = 1'b1; f_adata = DW'('h100 + i); f_akeep = '1; f_atlast = (i == 2);
      @(negedge clk);
      chk("fo_aready", f_aready, 1'b1);
      tick();
      chk("fo_bvalid", f_bvalid, 1'b1);
      chk("fo_bdata", f_bdata, DW'('h100 + i));
      chk("fo_btuser", f_btuser, (i == 0) ? TW'('hABCD) : TW'(0));
      chk("fo_btlast", f_btlast, i == 2);
    end
    f_avalid = 1'b0;
    tick();
    chk("fo_idle", f_bvalid, 1'b0);
    chk("fo_pkt", f_pkt, 1);
    chk("fo_state", f_dstate, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
